spike_aer_arbiter: RTL and testbench
====================================

# spike_aer_arbiter

Collects single-cycle `out_spike` pulses from `N_NEURON` parallel neuron_body instances in one layer. Serializes them into a stream of address events (AER) on a valid/ready port for the next layer or the spike router. Each neuron gets a sticky pending bit. Grants are round-robin, so one neuron that fires continuously cannot starve the others. Spikes that arrive while the same neuron's previous spike is still pending are dropped and flagged.

## Interface
Parameters:
- `N_NEURON`, 8: number of neuron_body spike inputs; must be ≥ 2.
- `ADDR_WIDTH`, 3: event address width; must equal ceil(log2(`N_NEURON`)).
- `DROP_CNT_WIDTH`, 8: width of the saturating drop counter (only used with `SPIKE_AER_DROP_CNT_EN`).

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_spike`  in  `N_NEURON`  bit i = `out_spike` of neuron i; single-cycle pulses; any number may be high in the same cycle.
- `out_valid`  out  1  an event is presented on `out_addr`.
- `out_ready`  in  1  consumer accepts the event this cycle.
- `out_addr`  out  `ADDR_WIDTH`  index of the spiking neuron.
- `busy`  out  1  high when any pending bit is set or `out_valid` is high.
- `overflow`  out  1  one-cycle pulse: at least one spike was dropped at the previous edge.
- `drop_cnt`  out  `DROP_CNT_WIDTH`  saturating count of dropped spikes; present only with the macro.

## Operation
- `pending[N_NEURON-1:0]`: bit i is set at an edge where `in_spike[i]`=1.
- Bit i is cleared at the edge where neuron i is granted, unless `in_spike[i]`=1 in that same cycle. In that case the bit stays set and nothing is dropped.
- **Drop:** `in_spike[i]`=1 while `pending[i]`=1 and neuron i is not granted that cycle.
  - The spike is lost and `pending[i]` stays 1.
  - `overflow`=1 on the next cycle. Several drops in one cycle give one pulse.
- **Load condition:** `load` = !`out_valid` | `out_ready`.
- **Arbitration:** when `load`=1 and `pending` is non-zero:
  - Search indices `ptr`, `ptr`+1, … with wrap-around at `N_NEURON`-1 → 0.
  - The first set bit g is granted.
  - At the edge: `out_addr` ← g, `out_valid` ← 1, `pending[g]` cleared, `ptr` ← (g+1) mod `N_NEURON`.
- Arbitration looks only at registered `pending`; there is no combinational bypass from `in_spike`.
- When `load`=1 and `pending`=0: `out_valid` ← 0, and `out_addr` and `ptr` hold.
- When `out_valid`=1 and `out_ready`=0: `out_addr` and `out_valid` are held unchanged (standard valid/ready rule). `ptr` holds.
- `busy` is combinational from `pending` and `out_valid`.
- `rst` mid-operation discards all pending spikes and any presented event. No `overflow` is generated for spikes discarded by reset.

## Timing
- Reset values: `pending`=0, `ptr`=0, `out_valid`=0, `out_addr`=0, `overflow`=0, `drop_cnt`=0.
- Latency: spike sampled at edge k sets pending at k. The earliest `out_valid`=1 is after edge k+1 (2 cycles from pulse to event).
- Throughput: one event per cycle while `out_ready`=1 and spikes are pending.
- Drain time: a burst of all N neurons drains in N cycles with `out_ready` held high.
- Fairness: a neuron that continuously re-spikes is granted at most once per N grants while the others are pending.

## Configuration
- Macro `SPIKE_AER_DROP_CNT_EN`.
- **Defined:**
  - `drop_cnt` port exists.
  - It increments by the number of spikes dropped in each cycle.
  - It saturates at 2^`DROP_CNT_WIDTH`-1.
  - It is cleared only by `rst`.
- **Undefined:** the port and the counter are absent. `overflow` behaviour is identical in both cases.

## Structure
- Shared package `snn_pkg`:
  - `N_NEURON` and `ADDR_WIDTH` defaults.
  - An `aer_event_t` typedef (address field).
  - These are shared with neuron_body arrays and the router.
- Sub-module `rr_priority_pick`:
  - Combinational round-robin picker.
  - Inputs: request vector, pointer. Outputs: `any`, grant index.
  - Reused by the planned spike router.

## Test plan
- **Reset:** hold `rst`=1 for 2 cycles while `in_spike`=8'hFF → `out_valid`=0, `busy`=0, `out_addr`=0 throughout. After release with `in_spike`=0, outputs stay idle.
- **Single spike:** `in_spike`=8'h10 for one cycle, `out_ready`=1 → exactly one event `out_addr`=4, 2 cycles after the pulse. Then `busy`=0.
- **Burst and round-robin:** starting from `ptr`=0, `in_spike`=8'hA5 for one cycle, `out_ready`=1 → events 0, 2, 5, 7 on consecutive cycles. A following pulse `in_spike`=8'h01 yields address 0, because `ptr` has wrapped to 0.
- **Backpressure:** `in_spike`=8'h06 with `out_ready`=0 for 5 cycles → `out_addr`=1 stable with `out_valid` held. After `out_ready`=1: events 1 then 2.
- **Drop:** `out_ready`=0, `in_spike[3]` pulsed twice, 2 cycles apart → one `overflow` pulse. With the macro, `drop_cnt`=1. After `out_ready`=1, only one event with address 3.
- **Same-cycle grant and re-spike:** neuron 2 pending and being granted while `in_spike[2]`=1 → no `overflow`, and a second event with address 2 follows.

Source files
------------

// File: rtl/snn_pkg.sv
// snn_pkg: layer-wide SNN defaults and the AER event type shared by neuron arrays, arbiters and the router
package snn_pkg;
    localparam int N_NEURON_DEF   = 8;
    localparam int ADDR_WIDTH_DEF = 3;
    typedef struct packed {
        logic [ADDR_WIDTH_DEF-1:0] addr;
    } aer_event_t;
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational round-robin picker
// Ports: req_i request vector, ptr_i highest-priority index,
//        any_o some request is set, idx_o first set index at or after ptr_i (wrapping)
module rr_priority_pick #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic         any_o,
    output logic [W-1:0] idx_o
);
    always_comb begin
        int s;
        logic [W-1:0] j;
        any_o = |req_i;
        idx_o = '0;
        // Scan from farthest to nearest so the nearest hit wins.
        for (int k = N - 1; k >= 0; k--) begin
            s = int'(ptr_i) + k;
            j = W'(s >= N ? s - N : s);
            if (req_i[j]) idx_o = j;
        end
    end
endmodule

// File: rtl/spike_aer_arbiter.sv
// spike_aer_arbiter: serializes per-neuron spike pulses into a round-robin AER valid/ready stream
// Ports: clk, rst (sync, active-high); in_spike one pulse bit per neuron;
//        out_valid/out_ready/out_addr event handshake; busy work outstanding;
//        overflow one-cycle pulse after any dropped spike;
//        drop_cnt saturating drop count (only with SPIKE_AER_DROP_CNT_EN defined)
module spike_aer_arbiter
    import snn_pkg::*;
#(
    parameter int N_NEURON       = N_NEURON_DEF,
    parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_NEURON-1:0]       in_spike,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ADDR_WIDTH-1:0]     out_addr,
    output logic                      busy,
    output logic                      overflow
`ifdef SPIKE_AER_DROP_CNT_EN
    ,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt
`endif
);
    if (N_NEURON < 2 || ADDR_WIDTH != $clog2(N_NEURON) || DROP_CNT_WIDTH < 1) begin : g_bad_cfg
        $error("spike_aer_arbiter: inconsistent parameters");
    end

    logic [N_NEURON-1:0]   pending_q, pending_d, grant, drop;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, addr_q, addr_d, gidx;
    logic                  valid_q, valid_d, ovf_q, ovf_d, any, load, take;

    rr_priority_pick #(.N(N_NEURON), .W(ADDR_WIDTH)) u_pick (
        .req_i (pending_q),
        .ptr_i (ptr_q),
        .any_o (any),
        .idx_o (gidx)
    );

    always_comb begin
        load      = !valid_q || out_ready;
        take      = load && any;
        grant     = take ? (N_NEURON'(1) << gidx) : '0;
        // A re-spike on the granted neuron re-arms its bit instead of dropping.
        drop      = in_spike & pending_q & ~grant;
        pending_d = (pending_q & ~grant) | in_spike;
        valid_d   = load ? any : valid_q;
        addr_d    = take ? gidx : addr_q;
        ptr_d     = take ? (gidx == ADDR_WIDTH'(N_NEURON - 1) ? '0 : gidx + 1'b1) : ptr_q;
        ovf_d     = |drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            ptr_q     <= '0;
            valid_q   <= 1'b0;
            addr_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            valid_q   <= valid_d;
            addr_q    <= addr_d;
            ovf_q     <= ovf_d;
        end
    end

    assign out_valid = valid_q;
    assign out_addr  = addr_q;
    assign overflow  = ovf_q;
    assign busy      = (|pending_q) || valid_q;

`ifdef SPIKE_AER_DROP_CNT_EN
    localparam int CW = $clog2(N_NEURON + 1);
    localparam int SW = DROP_CNT_WIDTH + 1;
    logic [CW-1:0]             n_drop;
    logic [SW-1:0]             cnt_sum;
    logic [DROP_CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        n_drop = '0;
        for (int i = 0; i < N_NEURON; i++) n_drop = n_drop + CW'(drop[i]);
        cnt_sum = {1'b0, cnt_q} + SW'(n_drop);
        cnt_d   = cnt_sum[SW-1] ? '1 : cnt_sum[DROP_CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign drop_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_spike_aer_arbiter.sv
module tb_spike_aer_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_spike = '0;
    logic       out_ready = 1'b1;
    logic       out_valid, busy, overflow;
    logic [2:0] out_addr;
`ifdef SPIKE_AER_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int n_chk = 0;
    int n_pass = 0;

    spike_aer_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .in_spike (in_spike),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_addr (out_addr),
        .busy     (busy),
        .overflow (overflow)
`ifdef SPIKE_AER_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int r; int spike; int rdy;
        int v; int a; int b; int o; int d;
    } vec_t;

    vec_t tv[35];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step(input int r, input int spike, input int rdy);
        rst       = (r != 0);
        in_spike  = 8'(spike);
        out_ready = (rdy != 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        tv[0]  = '{1, 'hFF, 1, 0, 0, 0, 0, 0};
        tv[1]  = '{1, 'hFF, 1, 0, 0, 0, 0, 0};
        tv[2]  = '{0, 'h00, 1, 0, 0, 0, 0, 0};
        tv[3]  = '{0, 'h00, 1, 0, 0, 0, 0, 0};
        tv[4]  = '{0, 'h10, 1, 0, 0, 1, 0, 0};
        tv[5]  = '{0, 'h00, 1, 1, 4, 1, 0, 0};
        tv[6]  = '{0, 'h00, 1, 0, 4, 0, 0, 0};
        tv[7]  = '{1, 'h00, 1, 0, 0, 0, 0, 0};
        tv[8]  = '{0, 'hA5, 1, 0, 0, 1, 0, 0};
        tv[9]  = '{0, 'h00, 1, 1, 0, 1, 0, 0};
        tv[10] = '{0, 'h00, 1, 1, 2, 1, 0, 0};
        tv[11] = '{0, 'h00, 1, 1, 5, 1, 0, 0};
        tv[12] = '{0, 'h00, 1, 1, 7, 1, 0, 0};
        tv[13] = '{0, 'h01, 1, 0, 7, 1, 0, 0};
        tv[14] = '{0, 'h00, 1, 1, 0, 1, 0, 0};
        tv[15] = '{0, 'h00, 1, 0, 0, 0, 0, 0};
        tv[16] = '{0, 'h06, 0, 0, 0, 1, 0, 0};
        tv[17] = '{0, 'h00, 0, 1, 1, 1, 0, 0};
        tv[18] = '{0, 'h00, 0, 1, 1, 1, 0, 0};
        tv[19] = '{0, 'h00, 0, 1, 1, 1, 0, 0};
        tv[20] = '{0, 'h00, 0, 1, 1, 1, 0, 0};
        tv[21] = '{0, 'h00, 1, 1, 2, 1, 0, 0};
        tv[22] = '{0, 'h00, 1, 0, 2, 0, 0, 0};
        tv[23] = '{0, 'h01, 0, 0, 2, 1, 0, 0};
        tv[24] = '{0, 'h08, 0, 1, 0, 1, 0, 0};
        tv[25] = '{0, 'h00, 0, 1, 0, 1, 0, 0};
        tv[26] = '{0, 'h08, 0, 1, 0, 1, 1, 1};
        tv[27] = '{0, 'h00, 0, 1, 0, 1, 0, 1};
        tv[28] = '{0, 'h00, 1, 1, 3, 1, 0, 1};
        tv[29] = '{0, 'h00, 1, 0, 3, 0, 0, 1};
        tv[30] = '{0, 'h00, 1, 0, 3, 0, 0, 1};
        tv[31] = '{0, 'h04, 1, 0, 3, 1, 0, 1};
        tv[32] = '{0, 'h04, 1, 1, 2, 1, 0, 1};
        tv[33] = '{0, 'h00, 1, 1, 2, 1, 0, 1};
        tv[34] = '{0, 'h00, 1, 0, 2, 0, 0, 1};

        for (int i = 0; i < 35; i++) begin
            step(tv[i].r, tv[i].spike, tv[i].rdy);
            chk($sformatf("vec%0d.valid", i), int'(out_valid), tv[i].v);
            chk($sformatf("vec%0d.addr", i), int'(out_addr), tv[i].a);
            chk($sformatf("vec%0d.busy", i), int'(busy), tv[i].b);
            chk($sformatf("vec%0d.overflow", i), int'(overflow), tv[i].o);
`ifdef SPIKE_AER_DROP_CNT_EN
            chk($sformatf("vec%0d.drop_cnt", i), int'(drop_cnt), tv[i].d);
`endif
        end

        // Fairness: full burst while neuron 0 keeps re-spiking still rotates 0..7 then 0.
        step(1, 'h00, 1);
        step(0, 'hFF, 1);
        for (int e = 0; e < 9; e++) begin
            step(0, 'h01, 1);
            chk($sformatf("fair%0d.valid", e), int'(out_valid), 1);
            chk($sformatf("fair%0d.addr", e), int'(out_addr), e % 8);
        end
        step(0, 'h00, 1);
        chk("fair_tail.addr", int'(out_addr), 0);
        chk("fair_tail.valid", int'(out_valid), 1);
        step(0, 'h00, 1);
        chk("fair_idle.valid", int'(out_valid), 0);
        chk("fair_idle.busy", int'(busy), 0);

        // Multiple drops in one cycle give a single overflow flag per cycle.
        step(1, 'h00, 1);
        step(0, 'h03, 0);
        step(0, 'h00, 0);
        chk("mdrop.addr", int'(out_addr), 0);
        step(0, 'h03, 0);
        chk("mdrop1.overflow", int'(overflow), 1);
        step(0, 'h03, 0);
        chk("mdrop2.overflow", int'(overflow), 1);
        step(0, 'h00, 0);
        chk("mdrop3.overflow", int'(overflow), 0);
`ifdef SPIKE_AER_DROP_CNT_EN
        chk("mdrop.drop_cnt", int'(drop_cnt), 3);
        for (int i = 0; i < 130; i++) step(0, 'h03, 0);
        chk("sat.drop_cnt", int'(drop_cnt), 255);
`endif
        step(1, 'h03, 0);
        chk("rst_discard.overflow", int'(overflow), 0);
        chk("rst_discard.busy", int'(busy), 0);
        chk("rst_discard.valid", int'(out_valid), 0);
`ifdef SPIKE_AER_DROP_CNT_EN
        chk("rst_discard.drop_cnt", int'(drop_cnt), 0);
`endif
        step(0, 'h00, 1);
        chk("post_rst.busy", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
